// File: rtl/cache_pkg.sv
// Shared types and default widths for the cache refill controller.
// REFILL_WRITEBACK_EN adds the WB_REQ state used for dirty-victim write-back.
package cache_pkg;

  localparam int NUM_OF_SETS_SQRT = 2;
  localparam int INDEX_WIDTH      = 4;
  localparam int TAG_WIDTH        = 8;
  localparam int LINE_WIDTH       = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
`ifdef REFILL_WRITEBACK_EN
    WB_REQ,
`endif
    FILL_REQ,
    FILL_WAIT,
    UPDATE
  } refill_state_t;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]   tag;
    logic [INDEX_WIDTH-1:0] index;
  } line_addr_t;

endpackage

// File: rtl/cache_refill_ctrl.sv
// Miss-handling FSM: picks the LRU victim, fetches the line, writes the arrays and updates LRU.
// Define REFILL_WRITEBACK_EN to write dirty victims back before the fill.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int num_of_sets_sqrt = NUM_OF_SETS_SQRT,
  parameter int index_width      = INDEX_WIDTH,
  parameter int tag_width        = TAG_WIDTH,
  parameter int line_width       = LINE_WIDTH
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           miss_valid_i,
  output logic                           miss_ready_o,
  input  logic [index_width-1:0]         miss_index_i,
  input  logic [tag_width-1:0]           miss_tag_i,
  output logic [index_width-1:0]         lru_address_o,
  input  logic [num_of_sets_sqrt-1:0]    lru_set_i,
  output logic                           lru_write_en_o,
  output logic [num_of_sets_sqrt-1:0]    lru_set_num_o,
  output logic                           mem_req_valid_o,
  input  logic                           mem_req_ready_i,
  output logic                           mem_req_we_o,
  output logic [tag_width+index_width-1:0] mem_req_addr_o,
  output logic [line_width-1:0]          mem_wdata_o,
  input  logic                           mem_rsp_valid_i,
  input  logic [line_width-1:0]          mem_rsp_data_i,
  output logic                           arr_write_en_o,
  output logic [index_width-1:0]         arr_index_o,
  output logic [num_of_sets_sqrt-1:0]    arr_set_o,
  output logic [tag_width-1:0]           arr_tag_o,
  output logic [line_width-1:0]          arr_data_o,
`ifdef REFILL_WRITEBACK_EN
  input  logic                           victim_dirty_i,
  input  logic [tag_width-1:0]           victim_tag_i,
  input  logic [line_width-1:0]          victim_data_i,
`endif
  output logic                           done_o
);

  refill_state_t                 r_state;
  logic [index_width-1:0]        r_index;
  logic [tag_width-1:0]          r_tag;
  logic [num_of_sets_sqrt-1:0]   r_victim;

`ifdef REFILL_WRITEBACK_EN
  logic                          r_we;
  logic [line_width-1:0]         r_wdata;

  assign mem_req_we_o = r_we;
  assign mem_wdata_o  = r_wdata;
`else
  assign mem_req_we_o = 1'b0;
  assign mem_wdata_o  = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state         <= IDLE;
      r_index         <= '0;
      r_tag           <= '0;
      r_victim        <= '0;
      miss_ready_o    <= 1'b1;
      lru_address_o   <= '0;
      lru_write_en_o  <= 1'b0;
      lru_set_num_o   <= '0;
      mem_req_valid_o <= 1'b0;
      mem_req_addr_o  <= '0;
      arr_write_en_o  <= 1'b0;
      arr_index_o     <= '0;
      arr_set_o       <= '0;
      arr_tag_o       <= '0;
      arr_data_o      <= '0;
      done_o          <= 1'b0;
`ifdef REFILL_WRITEBACK_EN
      r_we            <= 1'b0;
      r_wdata         <= '0;
`endif
    end else begin
      // Update strobes are single-cycle pulses; only the FILL_WAIT exit raises them.
      lru_write_en_o <= 1'b0;
      arr_write_en_o <= 1'b0;
      done_o         <= 1'b0;

      unique case (r_state)
        IDLE: begin
          if (miss_valid_i) begin
            r_index       <= miss_index_i;
            r_tag         <= miss_tag_i;
            lru_address_o <= miss_index_i;
            miss_ready_o  <= 1'b0;
            r_state       <= LOOKUP;
          end
        end

        LOOKUP: begin
          r_victim        <= lru_set_i;
          mem_req_valid_o <= 1'b1;
`ifdef REFILL_WRITEBACK_EN
          if (victim_dirty_i) begin
            r_we           <= 1'b1;
            r_wdata        <= victim_data_i;
            mem_req_addr_o <= {victim_tag_i, r_index};
            r_state        <= WB_REQ;
          end else begin
            r_we           <= 1'b0;
            mem_req_addr_o <= {r_tag, r_index};
            r_state        <= FILL_REQ;
          end
`else
          mem_req_addr_o  <= {r_tag, r_index};
          r_state         <= FILL_REQ;
`endif
        end

`ifdef REFILL_WRITEBACK_EN
        WB_REQ: begin
          // Valid stays high straight into the fill request; only addr/we change.
          if (mem_req_ready_i) begin
            r_we           <= 1'b0;
            mem_req_addr_o <= {r_tag, r_index};
            r_state        <= FILL_REQ;
          end
        end
`endif

        FILL_REQ: begin
          if (mem_req_ready_i) begin
            mem_req_valid_o <= 1'b0;
            r_state         <= FILL_WAIT;
          end
        end

        FILL_WAIT: begin
          if (mem_rsp_valid_i) begin
            arr_data_o     <= mem_rsp_data_i;
            arr_index_o    <= r_index;
            arr_set_o      <= r_victim;
            arr_tag_o      <= r_tag;
            arr_write_en_o <= 1'b1;
            lru_address_o  <= r_index;
            lru_set_num_o  <= r_victim;
            lru_write_en_o <= 1'b1;
            done_o         <= 1'b1;
            r_state        <= UPDATE;
          end
        end

        UPDATE: begin
          miss_ready_o <= 1'b1;
          r_state      <= IDLE;
        end

        default: begin
          miss_ready_o    <= 1'b1;
          mem_req_valid_o <= 1'b0;
          r_state         <= IDLE;
        end
      endcase
    end
  end

endmodule
